// File: rtl/bin_stim_gen_if.sv
// Counter-side bus between the stimulus generator (master) and the
// universal binary counter under test (slave).
interface bin_stim_gen_if #(
    parameter int N = 3
);
    logic         syn_clr;
    logic         load;
    logic         en;
    logic         up;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic         max_tick;
    logic         min_tick;

    modport master (
        output syn_clr, load, en, up, d,
        input  q, max_tick, min_tick
    );

    modport slave (
        input  syn_clr, load, en, up, d,
        output q, max_tick, min_tick
    );
endinterface

// File: rtl/bin_stim_gen.sv
// Self-sequencing stimulus generator for an N-bit universal binary counter.
// Each pass: clear, load, count up to wrap, count down to wrap, hold; the
// counter's ticks and hold behaviour are checked along the way.
module bin_stim_gen #(
    parameter int N           = 3,
    parameter int RUNS        = 4,
    parameter int SEED        = 3,
    parameter int STEP        = 3,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,     // asynchronous, active low
    input  logic                  start_i,
    bin_stim_gen_if.master        cnt,
    output logic [2:0]            phase_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int CW = N + 2;
    localparam int RW = $clog2(RUNS + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [N-1:0]  SEED_V    = N'(SEED);
    localparam logic [N-1:0]  STEP_V    = N'(STEP);
    // Last legal cyc_cnt value before the 2^N+2 edge timeout fires.
    localparam logic [CW-1:0] TMO_LAST  = CW'(2**N + 1);
    localparam logic [RW-1:0] RUNS_LAST = RW'(RUNS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LOAD = 3'd2,
        S_UP   = 3'd3,
        S_DOWN = 3'd4,
        S_HOLD = 3'd5,
        S_DONE = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cyc_q, cyc_d;
    logic [RW-1:0]  run_q, run_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [N-1:0]   d_q, d_d;
    logic [N-1:0]   qhold_q, qhold_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            run_q   <= '0;
            hold_q  <= '0;
            d_q     <= SEED_V;
            qhold_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            run_q   <= run_d;
            hold_q  <= hold_d;
            d_q     <= d_d;
            qhold_q <= qhold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        run_d   = run_q;
        hold_d  = hold_q;
        d_d     = d_q;
        qhold_d = qhold_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d = S_CLR;
                    d_d     = SEED_V;
                    run_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_CLR: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_UP;
                cyc_d   = '0;
            end
            S_UP: begin
                if (cnt.max_tick) begin
                    state_d = S_DOWN;
                    cyc_d   = '0;
                end else if (cyc_q == TMO_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_DOWN: begin
                // The first DOWN sample still sees the 0 left by the up-wrap.
                if (cnt.min_tick && (cyc_q != '0)) begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                    // The counter wraps 0 -> max on this edge; that is the
                    // value it must keep for the whole hold window.
                    qhold_d = cnt.q - N'(1);
                end else if (cyc_q == TMO_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt.q != qhold_q) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (hold_q == HOLD_LAST) begin
                    run_d = run_q + RW'(1);
                    d_d   = d_q + STEP_V;
                    if (run_q == RUNS_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CLR;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        cnt.syn_clr = (state_q == S_CLR);
        cnt.load    = (state_q == S_LOAD);
        cnt.en      = (state_q == S_UP) || (state_q == S_DOWN);
        cnt.up      = (state_q == S_UP);
        cnt.d       = d_q;
        phase_o     = state_q;
        busy_o      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
        done_o      = done_q;
        err_o       = err_q;
    end

endmodule
